// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and ALU operand selection.
// Define IDEX_FORWARD_EN to enable EX/MEM and MEM/WB result forwarding onto operands A and B.
module id_ex_stage #(
    parameter logic [3:0] RESET_CTL = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rdata1,
    input  logic [31:0] id_rdata2,
    input  logic [31:0] id_imm,
    input  logic        id_alusrc,
    input  logic [3:0]  id_aluctl,
    input  logic        id_regdst,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic        id_memtoreg,
    input  logic        exmem_regwrite,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_regwrite,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic [3:0]  alu_ctl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [31:0] ex_wdata,
    output logic [4:0]  ex_wreg,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        ex_memtoreg,
    output logic        ex_valid,
    output logic        load_use
);

    logic [4:0]  rs_q, rs_d;
    logic [4:0]  rt_q, rt_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic [31:0] rdata2_q, rdata2_d;
    logic [31:0] imm_q, imm_d;
    logic        alusrc_q, alusrc_d;
    logic [3:0]  aluctl_q, aluctl_d;
    logic [4:0]  wreg_q, wreg_d;
    logic        regwrite_q, regwrite_d;
    logic        memread_q, memread_d;
    logic        memwrite_q, memwrite_d;
    logic        memtoreg_q, memtoreg_d;
    logic        valid_q, valid_d;
    logic [31:0] fwd_a, fwd_b;

    assign load_use = valid_q & memread_q & (wreg_q != 5'd0) &
                      ((wreg_q == id_rs) | (wreg_q == id_rt));

    always_comb begin
        rs_d       = rs_q;
        rt_d       = rt_q;
        rdata1_d   = rdata1_q;
        rdata2_d   = rdata2_q;
        imm_d      = imm_q;
        alusrc_d   = alusrc_q;
        aluctl_d   = aluctl_q;
        wreg_d     = wreg_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        memtoreg_d = memtoreg_q;
        valid_d    = valid_q;
        if (stall) begin
            // a flush or hazard seen while stalled is deliberately dropped here
        end else if (flush || load_use) begin
            rs_d       = 5'd0;
            rt_d       = 5'd0;
            rdata1_d   = 32'd0;
            rdata2_d   = 32'd0;
            imm_d      = 32'd0;
            alusrc_d   = 1'b0;
            aluctl_d   = RESET_CTL;
            wreg_d     = 5'd0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            valid_d    = 1'b0;
        end else begin
            rs_d       = id_rs;
            rt_d       = id_rt;
            rdata1_d   = id_rdata1;
            rdata2_d   = id_rdata2;
            imm_d      = id_imm;
            alusrc_d   = id_alusrc;
            aluctl_d   = id_aluctl;
            wreg_d     = id_regdst ? id_rd : id_rt;
            regwrite_d = id_regwrite;
            memread_d  = id_memread;
            memwrite_d = id_memwrite;
            memtoreg_d = id_memtoreg;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_q       <= 5'd0;
            rt_q       <= 5'd0;
            rdata1_q   <= 32'd0;
            rdata2_q   <= 32'd0;
            imm_q      <= 32'd0;
            alusrc_q   <= 1'b0;
            aluctl_q   <= RESET_CTL;
            wreg_q     <= 5'd0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rdata1_q   <= rdata1_d;
            rdata2_q   <= rdata2_d;
            imm_q      <= imm_d;
            alusrc_q   <= alusrc_d;
            aluctl_q   <= aluctl_d;
            wreg_q     <= wreg_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            memtoreg_q <= memtoreg_d;
            valid_q    <= valid_d;
        end
    end

`ifdef IDEX_FORWARD_EN
    // EX/MEM is the younger producer, so it takes precedence over MEM/WB
    always_comb begin
        fwd_a = rdata1_q;
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rs_q))
            fwd_a = exmem_result;
        else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rs_q))
            fwd_a = memwb_result;
    end

    always_comb begin
        fwd_b = rdata2_q;
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rt_q))
            fwd_b = exmem_result;
        else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rt_q))
            fwd_b = memwb_result;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{exmem_regwrite, exmem_rd, exmem_result,
                          memwb_regwrite, memwb_rd, memwb_result, rs_q, rt_q};
    assign fwd_a = rdata1_q;
    assign fwd_b = rdata2_q;
`endif

    assign alu_a       = fwd_a;
    assign alu_b       = alusrc_q ? imm_q : fwd_b;
    assign ex_wdata    = fwd_b;
    assign alu_ctl     = aluctl_q;
    assign ex_wreg     = wreg_q;
    assign ex_regwrite = regwrite_q;
    assign ex_memread  = memread_q;
    assign ex_memwrite = memwrite_q;
    assign ex_memtoreg = memtoreg_q;
    assign ex_valid    = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage; expectations track IDEX_FORWARD_EN.
module tb_id_ex_stage;

    localparam logic [3:0] RCTL = 4'hA;
`ifdef IDEX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rdata1, id_rdata2, id_imm;
    logic        id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic [3:0]  id_aluctl;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_a, alu_b, ex_wdata;
    logic [4:0]  ex_wreg;
    logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_valid, load_use;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.RESET_CTL(RCTL)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_alusrc(id_alusrc), .id_aluctl(id_aluctl), .id_regdst(id_regdst),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .ex_wdata(ex_wdata),
        .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_valid(ex_valid),
        .load_use(load_use)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_rs = 0; id_rt = 0; id_rd = 0;
        id_rdata1 = 0; id_rdata2 = 0; id_imm = 0;
        id_alusrc = 0; id_aluctl = 0; id_regdst = 0;
        id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
    endtask

    task automatic clear_fwd();
        exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
        memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0;
        clear_id();
        clear_fwd();
        step();
        step();
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_ex_wdata", ex_wdata, 0);
        chk("rst_alu_ctl", {28'd0, alu_ctl}, {28'd0, RCTL});
        chk("rst_valid", {31'd0, ex_valid}, 0);
        chk("rst_wreg", {27'd0, ex_wreg}, 0);
        chk("rst_load_use", {31'd0, load_use}, 0);

        // basic capture
        rst = 0;
        id_rs = 1; id_rt = 2; id_rd = 4; id_rdata1 = 5; id_rdata2 = 7;
        id_aluctl = 4'b0010; id_regdst = 1; id_regwrite = 1;
        step();
        chk("cap_alu_a", alu_a, 5);
        chk("cap_alu_b", alu_b, 7);
        chk("cap_valid", {31'd0, ex_valid}, 1);
        chk("cap_ctl", {28'd0, alu_ctl}, 32'h2);
        chk("cap_wreg_rd", {27'd0, ex_wreg}, 4);
        chk("cap_regwrite", {31'd0, ex_regwrite}, 1);

        // double forwarding hit on rs=3
        clear_id();
        id_rs = 3; id_rdata1 = 32'h33; id_rdata2 = 32'h44; id_aluctl = 4'h1;
        step();
        exmem_regwrite = 1; exmem_rd = 3; exmem_result = 32'h11;
        memwb_regwrite = 1; memwb_rd = 3; memwb_result = 32'h22;
        #1;
        chk("fwd_exmem", alu_a, FWD ? 32'h11 : 32'h33);
        chk("fwd_wreg_rt", {27'd0, ex_wreg}, 0);
        exmem_regwrite = 0;
        #1;
        chk("fwd_memwb", alu_a, FWD ? 32'h22 : 32'h33);
        id_rs = 0; id_rdata1 = 32'h55;
        exmem_regwrite = 1; exmem_rd = 0; memwb_rd = 0;
        step();
        chk("fwd_idx0", alu_a, 32'h55);

        // immediate select with rt forwarded
        clear_fwd();
        clear_id();
        id_rt = 5; id_rdata2 = 32'h10; id_alusrc = 1; id_imm = 32'hFFFF_FFFC;
        exmem_regwrite = 1; exmem_rd = 5; exmem_result = 32'h99;
        step();
        chk("imm_alu_b", alu_b, 32'hFFFF_FFFC);
        chk("imm_wdata", ex_wdata, FWD ? 32'h99 : 32'h10);
        clear_fwd();

        // load-use on rs
        clear_id();
        id_rt = 8; id_memread = 1; id_regwrite = 1; id_memtoreg = 1; id_alusrc = 1; id_aluctl = 4'h2;
        step();
        chk("lw_memread", {31'd0, ex_memread}, 1);
        chk("lw_wreg", {27'd0, ex_wreg}, 8);
        clear_id();
        id_rs = 8; id_rdata1 = 32'h77; id_aluctl = 4'h3; id_regwrite = 1;
        #1;
        chk("lu_flag", {31'd0, load_use}, 1);
        step();
        chk("lu_bubble_valid", {31'd0, ex_valid}, 0);
        chk("lu_bubble_regwrite", {31'd0, ex_regwrite}, 0);
        chk("lu_bubble_ctl", {28'd0, alu_ctl}, {28'd0, RCTL});
        chk("lu_cleared", {31'd0, load_use}, 0);
        step();
        chk("lu_retry_valid", {31'd0, ex_valid}, 1);
        chk("lu_retry_ctl", {28'd0, alu_ctl}, 32'h3);
        chk("lu_retry_a", alu_a, 32'h77);

        // stall holds while ID inputs change
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            id_aluctl = 4'(i + 5);
            id_rdata1 = 32'(i * 256 + 1);
            step();
            chk("stall_ctl", {28'd0, alu_ctl}, 32'h3);
            chk("stall_a", alu_a, 32'h77);
            chk("stall_valid", {31'd0, ex_valid}, 1);
        end
        flush = 1;
        step();
        chk("stall_flush_valid", {31'd0, ex_valid}, 1);
        chk("stall_flush_ctl", {28'd0, alu_ctl}, 32'h3);
        stall = 0;
        step();
        chk("flush_valid", {31'd0, ex_valid}, 0);
        chk("flush_ctl", {28'd0, alu_ctl}, {28'd0, RCTL});
        chk("flush_a", alu_a, 0);
        flush = 0;
        clear_id();
        id_rs = 9; id_rdata1 = 32'h123; id_aluctl = 4'h6;
        step();
        chk("post_flush_a", alu_a, 32'h123);
        chk("post_flush_valid", {31'd0, ex_valid}, 1);

        // reset during stall
        stall = 1; rst = 1;
        step();
        chk("rst_stall_valid", {31'd0, ex_valid}, 0);
        chk("rst_stall_a", alu_a, 0);
        chk("rst_stall_ctl", {28'd0, alu_ctl}, {28'd0, RCTL});
        rst = 0; stall = 0;

        // load-use on rt while stalled: hold, then bubble
        clear_id();
        id_rt = 12; id_memread = 1; id_regwrite = 1;
        step();
        clear_id();
        id_rt = 12; id_rs = 1; id_aluctl = 4'h4;
        stall = 1;
        step();
        chk("lu_stall_hold", {31'd0, ex_memread}, 1);
        chk("lu_stall_flag", {31'd0, load_use}, 1);
        stall = 0;
        step();
        chk("lu_stall_bubble", {31'd0, ex_valid}, 0);
        step();
        chk("lu_stall_capture_ctl", {28'd0, alu_ctl}, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
